// File: rtl/threshold_peak_trigger.sv
// Self-trigger stage: fires on a rising threshold crossing, tracks the pulse with
// hysteresis, reports peak amplitude/position/width and holds off before re-arming.
module threshold_peak_trigger #(
   parameter int unsigned HOLDOFF   = 64,
   parameter int unsigned MAX_WIDTH = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic signed [15:0] din,
   input  logic signed [15:0] threshold,
   input  logic        [14:0] hysteresis,
   output logic               trigger,
   output logic               busy,
   output logic               peak_valid,
   output logic signed [15:0] peak_amp,
   output logic        [7:0]  peak_time,
   output logic        [7:0]  pulse_width,
   output logic               truncated,
   output logic        [31:0] trig_count
);

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 16;
   localparam int unsigned WW = 8;
   localparam int unsigned TW = 32;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF);
   localparam logic [WW-1:0] WIDTH_MAX = WW'(MAX_WIDTH);
   localparam bit            HAS_HOLD  = (HOLDOFF != 0);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_HOLDOFF} state_e;

   state_e                state_q, state_d;
   logic signed [DW-1:0]  din_q;
   logic                  smp_vld_q;
   logic signed [DW-1:0]  run_amp_q, run_amp_d;
   logic        [WW-1:0]  run_time_q, run_time_d;
   logic        [WW-1:0]  width_q, width_d;
   logic        [CW-1:0]  hold_q, hold_d;
   logic        [TW-1:0]  trig_count_q, trig_count_d;
   logic                  trigger_q, trigger_d;
   logic                  busy_q, busy_d;
   logic                  pv_q, pv_d;
   logic signed [DW-1:0]  amp_q, amp_d;
   logic        [WW-1:0]  ptime_q, ptime_d;
   logic        [WW-1:0]  pwidth_q, pwidth_d;
   logic                  trunc_q, trunc_d;

   logic                  eval_c;
   logic                  close_c;
   logic                  close_trunc_c;
   logic        [WW-1:0]  width_inc_c;
   logic signed [DW:0]    samp_c, thr_c, arm_c;

   // Comparisons are done one bit wider so threshold - hysteresis never wraps.
   assign samp_c      = $signed({din_q[DW-1], din_q});
   assign thr_c       = $signed({threshold[DW-1], threshold});
   assign arm_c       = thr_c - $signed({2'b00, hysteresis});
   assign eval_c      = enable & smp_vld_q;
   assign width_inc_c = width_q + WW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         din_q        <= '0;
         smp_vld_q    <= 1'b0;
         run_amp_q    <= '0;
         run_time_q   <= '0;
         width_q      <= '0;
         hold_q       <= '0;
         trig_count_q <= '0;
         trigger_q    <= 1'b0;
         busy_q       <= 1'b0;
         pv_q         <= 1'b0;
         amp_q        <= '0;
         ptime_q      <= '0;
         pwidth_q     <= '0;
         trunc_q      <= 1'b0;
      end else begin
         if (enable) begin
            din_q     <= din;
            smp_vld_q <= 1'b1;
         end
         state_q      <= state_d;
         run_amp_q    <= run_amp_d;
         run_time_q   <= run_time_d;
         width_q      <= width_d;
         hold_q       <= hold_d;
         trig_count_q <= trig_count_d;
         trigger_q    <= trigger_d;
         busy_q       <= busy_d;
         pv_q         <= pv_d;
         amp_q        <= amp_d;
         ptime_q      <= ptime_d;
         pwidth_q     <= pwidth_d;
         trunc_q      <= trunc_d;
      end
   end

   // Evaluation happens only on enabled edges with a captured sample; otherwise hold.
   always_comb begin
      state_d       = state_q;
      run_amp_d     = run_amp_q;
      run_time_d    = run_time_q;
      width_d       = width_q;
      hold_d        = hold_q;
      trig_count_d  = trig_count_q;
      trigger_d     = 1'b0;
      pv_d          = 1'b0;
      amp_d         = amp_q;
      ptime_d       = ptime_q;
      pwidth_d      = pwidth_q;
      trunc_d       = trunc_q;
      close_c       = 1'b0;
      close_trunc_c = 1'b0;

      if (eval_c) begin
         case (state_q)
            S_IDLE: begin
               if (samp_c < arm_c) state_d = S_ARMED;
            end
            S_ARMED: begin
               if (samp_c >= thr_c) begin
                  trigger_d    = 1'b1;
                  run_amp_d    = din_q;
                  run_time_d   = '0;
                  width_d      = WW'(1);
                  trig_count_d = trig_count_q + TW'(1);
                  state_d      = S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (samp_c < arm_c) begin
                  close_c = 1'b1;
               end else begin
                  width_d = width_inc_c;
                  if (din_q > run_amp_q) begin
                     run_amp_d  = din_q;
                     run_time_d = width_q;
                  end
                  if (width_inc_c >= WIDTH_MAX) begin
                     close_c       = 1'b1;
                     close_trunc_c = 1'b1;
                  end
               end
            end
            S_HOLDOFF: begin
               if (hold_q == HOLD_LAST) state_d = S_IDLE;
               else                     hold_d  = hold_q + CW'(1);
            end
            default: state_d = S_IDLE;
         endcase

         if (close_c) begin
            pv_d     = 1'b1;
            amp_d    = run_amp_d;
            ptime_d  = run_time_d;
            pwidth_d = width_d;
            trunc_d  = close_trunc_c;
            hold_d   = '0;
            state_d  = HAS_HOLD ? S_HOLDOFF : S_IDLE;
         end
      end

      busy_d = (state_d == S_ACTIVE) || (state_d == S_HOLDOFF);
   end

   assign trigger     = trigger_q;
   assign busy        = busy_q;
   assign peak_valid  = pv_q;
   assign peak_amp    = amp_q;
   assign peak_time   = ptime_q;
   assign pulse_width = pwidth_q;
   assign truncated   = trunc_q;
   assign trig_count  = trig_count_q;

endmodule

// File: tb/tb_threshold_peak_trigger.sv
// Bench for threshold_peak_trigger: directed and random sample streams compared
// cycle by cycle against a pulse-scanning reference model.
module tb_threshold_peak_trigger;

   localparam int unsigned HOLD = 64;
   localparam int unsigned MAXW = 255;
   localparam int          NMAX = 1024;

   typedef struct packed {
      logic               trig;
      logic               pv;
      logic               busy;
      logic signed [15:0] amp;
      logic        [7:0]  ptime;
      logic        [7:0]  width;
      logic               trunc;
      logic        [31:0] cnt;
   } snap_t;

   logic               clk;
   logic               reset;
   logic               enable;
   logic signed [15:0] din;
   logic signed [15:0] threshold;
   logic        [14:0] hysteresis;
   logic               trigger;
   logic               busy;
   logic               peak_valid;
   logic signed [15:0] peak_amp;
   logic        [7:0]  peak_time;
   logic        [7:0]  pulse_width;
   logic               truncated;
   logic        [31:0] trig_count;

   threshold_peak_trigger #(.HOLDOFF(HOLD), .MAX_WIDTH(MAXW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .din(din),
      .threshold(threshold), .hysteresis(hysteresis),
      .trigger(trigger), .busy(busy), .peak_valid(peak_valid),
      .peak_amp(peak_amp), .peak_time(peak_time), .pulse_width(pulse_width),
      .truncated(truncated), .trig_count(trig_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_tests;
   int    n_fail;
   int    thr_v;
   int    hys_v;
   int    samp    [NMAX];
   snap_t obs     [NMAX+1];
   snap_t exp_s   [NMAX+1];
   snap_t gap_obs [16];
   snap_t pv_q    [$];
   int    trig_q  [$];

   bit ev_trig  [NMAX];
   bit ev_close [NMAX];
   bit busy_a   [NMAX];
   int cl_amp   [NMAX];
   int cl_time  [NMAX];
   int cl_width [NMAX];
   bit cl_trunc [NMAX];

   function automatic snap_t snap();
      snap_t s;
      s.trig  = trigger;
      s.pv    = peak_valid;
      s.busy  = busy;
      s.amp   = peak_amp;
      s.ptime = peak_time;
      s.width = pulse_width;
      s.trunc = truncated;
      s.cnt   = trig_count;
      return s;
   endfunction

   task automatic apply_reset();
      reset      = 1'b1;
      enable     = 1'b1;
      din        = '0;
      threshold  = 16'(thr_v);
      hysteresis = 15'(hys_v);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Feeds samp[0..n-1] after a reset; obs[i] is taken just after the i-th enabled edge.
   task automatic drive_stream(input int n, input int gap_at, input int gap_len);
      apply_reset();
      pv_q.delete();
      trig_q.delete();
      for (int i = 0; i <= n; i++) begin
         if (i == gap_at) begin
            for (int k = 0; k < gap_len; k++) begin
               enable = 1'b0;
               din    = 16'($urandom);
               @(posedge clk);
               #1;
               gap_obs[k] = snap();
            end
            enable = 1'b1;
         end
         din = 16'(samp[(i < n) ? i : n - 1]);
         @(posedge clk);
         #1;
         obs[i] = snap();
         if (obs[i].pv)   pv_q.push_back(obs[i]);
         if (obs[i].trig) trig_q.push_back(i);
      end
   endtask

   // Scans the sample list pulse by pulse; exp_s[j+1] is the expected output after sample j.
   task automatic build_model(input int n);
      int    arm, j, t, c, width, pk, pt, bend;
      bit    closed, trunc;
      snap_t s;
      arm = thr_v - hys_v;
      for (int k = 0; k < n; k++) begin
         ev_trig[k] = 0; ev_close[k] = 0; busy_a[k] = 0;
         cl_amp[k] = 0; cl_time[k] = 0; cl_width[k] = 0; cl_trunc[k] = 0;
      end
      j = 0;
      while (j < n) begin
         while (j < n && samp[j] >= arm) j++;
         if (j >= n) break;
         j++;
         while (j < n && samp[j] < thr_v) j++;
         if (j >= n) break;
         t = j; ev_trig[t] = 1;
         width = 1; pk = samp[j]; pt = 0; trunc = 0; closed = 0;
         j++;
         while (j < n) begin
            if (samp[j] < arm) begin closed = 1; break; end
            width++;
            if (samp[j] > pk) begin pk = samp[j]; pt = width - 1; end
            if (width >= int'(MAXW)) begin closed = 1; trunc = 1; break; end
            j++;
         end
         c    = j;
         bend = !closed ? n - 1 : (HOLD == 0 ? c - 1 : c + int'(HOLD));
         for (int k = t; k <= bend && k < n; k++) busy_a[k] = 1;
         if (!closed) break;
         ev_close[c] = 1; cl_amp[c] = pk; cl_time[c] = pt;
         cl_width[c] = width; cl_trunc[c] = trunc;
         j = c + 1 + (HOLD > 0 ? int'(HOLD) + 1 : 0);
      end
      s = '0;
      exp_s[0] = s;
      for (int k = 0; k < n; k++) begin
         s.trig = ev_trig[k];
         s.pv   = ev_close[k];
         s.busy = busy_a[k];
         if (ev_trig[k]) s.cnt = s.cnt + 32'd1;
         if (ev_close[k]) begin
            s.amp   = 16'(cl_amp[k]);
            s.ptime = 8'(cl_time[k]);
            s.width = 8'(cl_width[k]);
            s.trunc = cl_trunc[k];
         end
         exp_s[k+1] = s;
      end
   endtask

   task automatic test_reset();
      int n;
      thr_v = 100; hys_v = 20;
      reset = 1'b1; enable = 1'b1; din = 16'sd500;
      threshold = 16'sd100; hysteresis = 15'd20;
      @(posedge clk); #1;
      n_tests++;
      if (snap() !== snap_t'('0)) begin
         n_fail++; $display("FAIL reset_state: got %h expected 0", snap());
      end
      n = 40;
      for (int i = 0; i < n; i++) samp[i] = 500;
      drive_stream(n, -1, 0);
      build_model(n);
      for (int i = 0; i <= n; i++) begin
         n_tests++;
         if (obs[i] !== exp_s[i]) begin
            n_fail++; $display("FAIL high_after_reset cyc %0d: got %h expected %h", i, obs[i], exp_s[i]);
         end
      end
      n_tests++;
      if (trig_q.size() != 0 || obs[n] !== snap_t'('0)) begin
         n_fail++; $display("FAIL high_after_reset_quiet: triggers %0d final %h expected 0", trig_q.size(), obs[n]);
      end
   endtask

   task automatic test_basic();
      int n;
      int seq [8] = '{0, 0, 50, 120, 300, 250, 70, 0};
      thr_v = 100; hys_v = 20; n = 8;
      for (int i = 0; i < n; i++) samp[i] = seq[i];
      drive_stream(n, -1, 0);
      build_model(n);
      for (int i = 0; i <= n; i++) begin
         n_tests++;
         if (obs[i] !== exp_s[i]) begin
            n_fail++; $display("FAIL basic cyc %0d: got %h expected %h", i, obs[i], exp_s[i]);
         end
      end
      n_tests++;
      if (trig_q.size() != 1 || trig_q[0] != 4) begin
         n_fail++; $display("FAIL basic_trig_time: got %0d triggers (first at %0d) expected 1 at 4",
                            trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1);
      end
      n_tests++;
      if (pv_q.size() != 1) begin
         n_fail++; $display("FAIL basic_close: got %0d closes expected 1", pv_q.size());
      end else if (pv_q[0].amp !== 16'sd300 || pv_q[0].ptime !== 8'd1 || pv_q[0].width !== 8'd3 ||
                   pv_q[0].trunc !== 1'b0 || pv_q[0].cnt !== 32'd1) begin
         n_fail++; $display("FAIL basic_fields: got amp=%0d t=%0d w=%0d tr=%b cnt=%0d expected 300 1 3 0 1",
                            pv_q[0].amp, pv_q[0].ptime, pv_q[0].width, pv_q[0].trunc, pv_q[0].cnt);
      end
   endtask

   task automatic test_hysteresis();
      int n;
      int seq [6] = '{0, 105, 85, 105, 79, 0};
      thr_v = 100; hys_v = 20; n = 6;
      for (int i = 0; i < n; i++) samp[i] = seq[i];
      drive_stream(n, -1, 0);
      build_model(n);
      for (int i = 0; i <= n; i++) begin
         n_tests++;
         if (obs[i] !== exp_s[i]) begin
            n_fail++; $display("FAIL hysteresis cyc %0d: got %h expected %h", i, obs[i], exp_s[i]);
         end
      end
      n_tests++;
      if (trig_q.size() != 1 || pv_q.size() != 1 || pv_q[0].width !== 8'd3 ||
          pv_q[0].amp !== 16'sd105 || pv_q[0].ptime !== 8'd0) begin
         n_fail++; $display("FAIL hysteresis_fields: got trigs=%0d closes=%0d expected 1 1 w=3 amp=105 t=0",
                            trig_q.size(), pv_q.size());
      end
   endtask

   task automatic test_truncation();
      int n;
      thr_v = 100; hys_v = 20; n = 408;
      samp[0] = 0;
      for (int i = 1; i <= 400; i++) samp[i] = 500;
      samp[401] = 50;
      for (int i = 402; i <= 406; i++) samp[i] = 500;
      samp[407] = 0;
      drive_stream(n, -1, 0);
      build_model(n);
      for (int i = 0; i <= n; i++) begin
         n_tests++;
         if (obs[i] !== exp_s[i]) begin
            n_fail++; $display("FAIL truncation cyc %0d: got %h expected %h", i, obs[i], exp_s[i]);
         end
      end
      n_tests++;
      if (pv_q.size() < 1 || pv_q[0].width !== 8'd255 || pv_q[0].trunc !== 1'b1 ||
          pv_q[0].ptime !== 8'd0 || pv_q[0].amp !== 16'sd500) begin
         n_fail++; $display("FAIL truncation_fields: got closes=%0d expected w=255 tr=1 t=0 amp=500", pv_q.size());
      end
      n_tests++;
      if (trig_q.size() != 2 || trig_q[1] != 403) begin
         n_fail++; $display("FAIL truncation_rearm: got %0d triggers expected 2 (second at 403)", trig_q.size());
      end
   endtask

   task automatic test_holdoff();
      int n;
      thr_v = 100; hys_v = 20; n = 92;
      for (int i = 0; i < n; i++) samp[i] = 0;
      for (int i = 1; i <= 3; i++)   samp[i] = 200;
      for (int i = 15; i <= 17; i++) samp[i] = 200;
      for (int i = 85; i <= 87; i++) samp[i] = 200;
      drive_stream(n, -1, 0);
      build_model(n);
      for (int i = 0; i <= n; i++) begin
         n_tests++;
         if (obs[i] !== exp_s[i]) begin
            n_fail++; $display("FAIL holdoff cyc %0d: got %h expected %h", i, obs[i], exp_s[i]);
         end
      end
      n_tests++;
      if (trig_q.size() != 2 || obs[n].cnt !== 32'd2) begin
         n_fail++; $display("FAIL holdoff_count: got trigs=%0d cnt=%0d expected 2 2", trig_q.size(), obs[n].cnt);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      thr_v = 100; hys_v = 20; n = 80;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < n; i++) samp[i] = 0;
         samp[1] = 200; samp[2] = 200; samp[70] = 200; samp[71] = 200;
         if (pass == 1) samp[69] = 200;
         drive_stream(n, -1, 0);
         build_model(n);
         for (int i = 0; i <= n; i++) begin
            n_tests++;
            if (obs[i] !== exp_s[i]) begin
               n_fail++; $display("FAIL back_to_back%0d cyc %0d: got %h expected %h", pass, i, obs[i], exp_s[i]);
            end
         end
         n_tests++;
         if (pass == 0 && (trig_q.size() != 2 || trig_q[1] - trig_q[0] != 69)) begin
            n_fail++; $display("FAIL back_to_back_spacing: got %0d triggers expected 2 spaced 69", trig_q.size());
         end else if (pass == 1 && trig_q.size() != 1) begin
            n_fail++; $display("FAIL back_to_back_early: got %0d triggers expected 1", trig_q.size());
         end
      end
   endtask

   task automatic test_enable_gap();
      int    n;
      snap_t held;
      int    seq [10] = '{0, 0, 150, 300, 200, 180, 90, 0, 0, 0};
      thr_v = 100; hys_v = 20; n = 10;
      for (int i = 0; i < n; i++) samp[i] = seq[i];
      drive_stream(n, 4, 5);
      build_model(n);
      held      = exp_s[3];
      held.trig = 1'b0;
      held.pv   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (gap_obs[k] !== held) begin
            n_fail++; $display("FAIL enable_freeze %0d: got %h expected %h", k, gap_obs[k], held);
         end
      end
      for (int i = 0; i <= n; i++) begin
         n_tests++;
         if (obs[i] !== exp_s[i]) begin
            n_fail++; $display("FAIL enable_resume cyc %0d: got %h expected %h", i, obs[i], exp_s[i]);
         end
      end
      n_tests++;
      if (pv_q.size() != 1 || pv_q[0].width !== 8'd5) begin
         n_fail++; $display("FAIL enable_width: got closes=%0d expected 1 with width 5", pv_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int n;
      thr_v = 100; hys_v = 20; n = 5;
      samp[0] = 0; samp[1] = 0; samp[2] = 300; samp[3] = 300; samp[4] = 300;
      drive_stream(n, -1, 0);
      n_tests++;
      if (obs[n].busy !== 1'b1 || obs[n].cnt !== 32'd1) begin
         n_fail++; $display("FAIL reset_mid_active: got busy=%b cnt=%0d expected 1 1", obs[n].busy, obs[n].cnt);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (snap() !== snap_t'('0)) begin
         n_fail++; $display("FAIL reset_mid_async: got %h expected 0", snap());
      end
      @(negedge clk);
      reset = 1'b0;
      din   = 16'sd300;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (snap() !== snap_t'('0)) begin
            n_fail++; $display("FAIL reset_mid_restart cyc %0d: got %h expected 0", i, snap());
         end
      end
   endtask

   task automatic test_random();
      int n, pos, arm, bl, pl;
      n = 400;
      for (int r = 0; r < 4; r++) begin
         thr_v = int'($urandom_range(0, 1500)) - 500;
         hys_v = int'($urandom_range(0, 200));
         arm   = thr_v - hys_v;
         pos   = 0;
         while (pos < n) begin
            bl = int'($urandom_range(1, 15));
            for (int k = 0; k < bl && pos < n; k++) samp[pos++] = arm - 1 - int'($urandom_range(0, 300));
            pl = ($urandom_range(0, 9) == 0) ? 270 : int'($urandom_range(1, 25));
            for (int k = 0; k < pl && pos < n; k++) samp[pos++] = arm + int'($urandom_range(0, hys_v + 400));
         end
         drive_stream(n, -1, 0);
         build_model(n);
         for (int i = 0; i <= n; i++) begin
            n_tests++;
            if (obs[i] !== exp_s[i]) begin
               n_fail++; $display("FAIL random%0d cyc %0d: got %h expected %h", r, i, obs[i], exp_s[i]);
            end
         end
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b1; enable = 1'b1; din = '0; threshold = '0; hysteresis = '0;
      test_reset();
      test_basic();
      test_hysteresis();
      test_truncation();
      test_holdoff();
      test_back_to_back();
      test_enable_gap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
